// File: rtl/pipe_reg_chain.sv
// Parametrised pipeline-register chain: per-stage valid, stall, flush, output backpressure,
// optional bubble collapse, and a saturating stall-cycle counter for performance debug.
module pipe_reg_chain #(
  parameter int                WIDTH     = 32,
  parameter int                STAGES    = 4,
  parameter int                COLLAPSE  = 0,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              in_valid,
  input  logic [WIDTH-1:0]                  in_data,
  output logic                              in_ready,
  input  logic [STAGES-1:0]                 stall,
  input  logic [STAGES-1:0]                 flush,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [WIDTH-1:0]                  out_data,
  output logic [STAGES-1:0]                 stage_valid,
  output logic [STAGES*WIDTH-1:0]           stage_data,
  output logic [$clog2(STAGES+1)-1:0]       occupancy,
  output logic [31:0]                       stall_cycles
);

  localparam int OCC_W = $clog2(STAGES+1);

  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0][WIDTH-1:0]  data_q, data_d;
  logic [STAGES-1:0]             hold;
  logic [31:0]                   stall_cnt_q, stall_cnt_d;
  logic [OCC_W-1:0]              occ;

  // Hold ripples from the last stage backwards; it only reads registered valid and inputs.
  always_comb begin
    logic h;
    hold = '0;
    if (COLLAPSE != 0) h = stall[STAGES-1] | (valid_q[STAGES-1] & ~out_ready);
    else               h = stall[STAGES-1] | ~out_ready;
    hold[STAGES-1] = h;
    for (int i = STAGES-2; i >= 0; i--) begin
      if (COLLAPSE != 0) h = stall[i] | (valid_q[i] & h);
      else               h = stall[i] | h;
      hold[i] = h;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush[0]) begin
      valid_d[0] = 1'b0;
      data_d[0]  = RESET_VAL;
    end else if (!hold[0]) begin
      valid_d[0] = in_valid;
      data_d[0]  = in_data;
    end
    // A stage that holds while its successor advances leaves a bubble behind it.
    for (int i = 1; i < STAGES; i++) begin
      if (flush[i]) begin
        valid_d[i] = 1'b0;
        data_d[i]  = RESET_VAL;
      end else if (!hold[i]) begin
        valid_d[i] = valid_q[i-1] & ~hold[i-1];
        data_d[i]  = data_q[i-1];
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < STAGES; i++)
      occ = occ + OCC_W'(valid_q[i]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q     <= '0;
      data_q      <= {STAGES{RESET_VAL}};
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready     = ~hold[0];
  assign out_valid    = valid_q[STAGES-1] & ~stall[STAGES-1];
  assign out_data     = data_q[STAGES-1];
  assign stage_valid  = valid_q;
  assign stage_data   = data_q;
  assign occupancy    = occ;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: one non-collapsing and one collapsing instance, four stages.
module tb_pipe_reg_chain;

  localparam int          W  = 32;
  localparam int          S  = 4;
  localparam logic [31:0] RV = 32'hDEAD_0000;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_ready, out_valid;
  logic [W-1:0]  in_data, out_data;
  logic [S-1:0]  stall, flush, stage_valid;
  logic [S*W-1:0] stage_data;
  logic [2:0]    occupancy;
  logic [31:0]   stall_cycles;

  logic          c_in_valid, c_in_ready, c_out_ready, c_out_valid;
  logic [W-1:0]  c_in_data, c_out_data;
  logic [S-1:0]  c_stall, c_flush, c_stage_valid;
  logic [S*W-1:0] c_stage_data;
  logic [2:0]    c_occupancy;
  logic [31:0]   c_stall_cycles;

  int checks = 0;
  int errors = 0;

  pipe_reg_chain #(.WIDTH(W), .STAGES(S), .COLLAPSE(0), .RESET_VAL(RV)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall(stall), .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .stage_valid(stage_valid), .stage_data(stage_data),
    .occupancy(occupancy), .stall_cycles(stall_cycles));

  pipe_reg_chain #(.WIDTH(W), .STAGES(S), .COLLAPSE(1), .RESET_VAL(RV)) dut_c (
    .clk(clk), .rstn(rstn), .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
    .stall(c_stall), .flush(c_flush), .out_ready(c_out_ready), .out_valid(c_out_valid),
    .out_data(c_out_data), .stage_valid(c_stage_valid), .stage_data(c_stage_data),
    .occupancy(c_occupancy), .stall_cycles(c_stall_cycles));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sd(input int i);
    return stage_data[i*W +: W];
  endfunction

  function automatic logic [31:0] csd(input int i);
    return c_stage_data[i*W +: W];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    in_valid = 0; in_data = '0; stall = '0; flush = '0; out_ready = 1;
    c_in_valid = 0; c_in_data = '0; c_stall = '0; c_flush = '0; c_out_ready = 1;

    // Reset state
    #1 rstn = 1'b0;
    #1;
    chk("rst_stage_valid", stage_valid, 4'b0000);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, RV);
    chk("rst_c_in_ready", c_in_ready, 1);
    @(negedge clk) rstn = 1'b1;
    step();

    // Streaming
    in_valid = 1; in_data = 32'h100; step();
    chk("st_in_ready", in_ready, 1);
    chk("st_s0", sd(0), 32'h100);
    in_data = 32'h104; step();
    in_data = 32'h108; step();
    chk("st_occ3", occupancy, 3);
    in_valid = 0; step();
    chk("st_ov4", out_valid, 1);
    chk("st_od4", out_data, 32'h100);
    step();
    chk("st_od5", out_data, 32'h104);
    step();
    chk("st_od6", out_data, 32'h108);
    step();
    chk("st_ov7", out_valid, 0);
    chk("st_occ7", occupancy, 0);
    chk("st_stallcnt", stall_cycles, 0);

    // Load-use stall on stage 1
    in_valid = 1; in_data = 32'h200; step();
    in_data = 32'h204; step();
    in_data = 32'h208; stall = 4'b0010; #1;
    chk("lu_in_ready", in_ready, 0);
    step();
    chk("lu_sv", stage_valid, 4'b0011);
    chk("lu_s0", sd(0), 32'h204);
    chk("lu_s1", sd(1), 32'h200);
    chk("lu_cnt", stall_cycles, 1);
    stall = '0; step();
    chk("lu_sv2", stage_valid, 4'b0111);
    chk("lu_bubble_out", out_valid, 0);
    in_data = 32'h20C; step();
    chk("lu_ov_a", out_valid, 1);
    chk("lu_od_a", out_data, 32'h200);
    in_valid = 0; step();
    chk("lu_od_b", out_data, 32'h204);
    step();
    chk("lu_od_c", out_data, 32'h208);
    step();
    chk("lu_od_d", out_data, 32'h20C);
    chk("lu_ov_d", out_valid, 1);
    chk("lu_cnt2", stall_cycles, 1);

    // Branch flush of stages 0 and 1
    in_valid = 1; in_data = 32'h308; step();
    in_data = 32'h304; step();
    in_data = 32'h300; step();
    chk("fl_sv_pre", stage_valid, 4'b0111);
    in_data = 32'h3FF; flush = 4'b0011; step();
    chk("fl_sv", stage_valid, 4'b1100);
    chk("fl_s0", sd(0), RV);
    chk("fl_s1", sd(1), RV);
    chk("fl_s2", sd(2), 32'h304);
    chk("fl_s3", sd(3), 32'h308);
    chk("fl_od", out_data, 32'h308);
    flush = '0; in_valid = 0; step();
    chk("fl_od2", out_data, 32'h304);
    step();
    chk("fl_occ", occupancy, 0);

    // Backpressure, both instances
    in_valid = 1; in_data = 32'h400; c_in_valid = 1; c_in_data = 32'h500; step();
    in_valid = 0; c_in_valid = 0; step(); step(); step();
    chk("bp_occ1", occupancy, 1);
    chk("bp_s3", sd(3), 32'h400);
    chk("bp_c_occ1", c_occupancy, 1);
    out_ready = 0; c_out_ready = 0;
    in_valid = 1; in_data = 32'h404; c_in_valid = 1; c_in_data = 32'h504; #1;
    chk("bp_in_ready0", in_ready, 0);
    chk("bp_c_rdy0", c_in_ready, 1);
    step();
    chk("bp_c_occ2", c_occupancy, 2);
    chk("bp_c_rdy1", c_in_ready, 1);
    c_in_data = 32'h508; step();
    chk("bp_c_occ3", c_occupancy, 3);
    chk("bp_c_rdy2", c_in_ready, 1);
    c_in_data = 32'h50C; step();
    chk("bp_c_occ4", c_occupancy, 4);
    chk("bp_c_rdy3", c_in_ready, 0);
    chk("bp_c_sv", c_stage_valid, 4'b1111);
    c_in_data = 32'h510; step();
    chk("bp_cnt", stall_cycles, 5);
    chk("bp_sv", stage_valid, 4'b1000);
    chk("bp_od_stable", out_data, 32'h400);
    chk("bp_ov", out_valid, 1);
    chk("bp_c_cnt", c_stall_cycles, 1);
    chk("bp_c_od", c_out_data, 32'h500);
    chk("bp_c_s0", csd(0), 32'h50C);
    out_ready = 1; c_out_ready = 1; c_in_valid = 0; #1;
    chk("bp_rel_rdy", in_ready, 1);
    chk("bp_rel_c_rdy", c_in_ready, 1);
    step();
    chk("bp_rel_c_od", c_out_data, 32'h504);
    chk("bp_rel_s0", sd(0), 32'h404);
    in_valid = 0; step(); step(); step();
    chk("bp_rel_od", out_data, 32'h404);
    chk("bp_rel_ov", out_valid, 1);
    chk("bp_rel_c_occ", c_occupancy, 0);
    step();
    chk("bp_rel_occ", occupancy, 0);

    // Asynchronous reset mid-flight
    in_valid = 1; in_data = 32'h600; step();
    in_data = 32'h604; step();
    in_data = 32'h608; step();
    in_valid = 0;
    chk("ar_occ_pre", occupancy, 3);
    #2 rstn = 1'b0;
    #1;
    chk("ar_sv", stage_valid, 4'b0000);
    chk("ar_ov", out_valid, 0);
    chk("ar_occ", occupancy, 0);
    chk("ar_cnt", stall_cycles, 0);
    chk("ar_od", out_data, RV);
    #2 rstn = 1'b1;
    in_valid = 1; in_data = 32'h700; step();
    in_valid = 0; step(); step();
    chk("ar_ov3", out_valid, 0);
    step();
    chk("ar_ov4", out_valid, 1);
    chk("ar_od4", out_data, 32'h700);

    // Counter saturation
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    #1;
    chk("sat_pre", stall_cycles, 32'hFFFF_FFFE);
    out_ready = 0; in_valid = 1; in_data = 32'h7FF; #1;
    chk("sat_rdy", in_ready, 0);
    step();
    chk("sat_1", stall_cycles, 32'hFFFF_FFFF);
    step(); step();
    chk("sat_3", stall_cycles, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
